// File: rtl/axi_arb_nto1.sv
// N-to-1 AXI arbiter: fixed priority by default, round-robin when
// AXI_ARB_RR_EN is defined. Master index rides in the upper ID bits.
module axi_arb_nto1 #(
  parameter int NUM_MST       = 2,
  parameter int AXI_WIDTH_CID = 4,
  parameter int AXI_WIDTH_ID  = 4,
  parameter int AXI_WIDTH_AD  = 32,
  parameter int AXI_WIDTH_DA  = 32,
  localparam int AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
  localparam int AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_MST*AXI_WIDTH_ID-1:0]   M_AWID,
  input  logic [NUM_MST*AXI_WIDTH_AD-1:0]   M_AWADDR,
  input  logic [NUM_MST*8-1:0]              M_AWLEN,
  input  logic [NUM_MST*3-1:0]              M_AWSIZE,
  input  logic [NUM_MST*2-1:0]              M_AWBURST,
  input  logic [NUM_MST-1:0]                M_AWVALID,
  output logic [NUM_MST-1:0]                M_AWREADY,
  input  logic [NUM_MST*AXI_WIDTH_DA-1:0]   M_WDATA,
  input  logic [NUM_MST*AXI_WIDTH_DS-1:0]   M_WSTRB,
  input  logic [NUM_MST-1:0]                M_WLAST,
  input  logic [NUM_MST-1:0]                M_WVALID,
  output logic [NUM_MST-1:0]                M_WREADY,
  output logic [NUM_MST*AXI_WIDTH_ID-1:0]   M_BID,
  output logic [NUM_MST*2-1:0]              M_BRESP,
  output logic [NUM_MST-1:0]                M_BVALID,
  input  logic [NUM_MST-1:0]                M_BREADY,
  input  logic [NUM_MST*AXI_WIDTH_ID-1:0]   M_ARID,
  input  logic [NUM_MST*AXI_WIDTH_AD-1:0]   M_ARADDR,
  input  logic [NUM_MST*8-1:0]              M_ARLEN,
  input  logic [NUM_MST*3-1:0]              M_ARSIZE,
  input  logic [NUM_MST*2-1:0]              M_ARBURST,
  input  logic [NUM_MST-1:0]                M_ARVALID,
  output logic [NUM_MST-1:0]                M_ARREADY,
  output logic [NUM_MST*AXI_WIDTH_ID-1:0]   M_RID,
  output logic [NUM_MST*AXI_WIDTH_DA-1:0]   M_RDATA,
  output logic [NUM_MST*2-1:0]              M_RRESP,
  output logic [NUM_MST-1:0]                M_RLAST,
  output logic [NUM_MST-1:0]                M_RVALID,
  input  logic [NUM_MST-1:0]                M_RREADY,
  output logic [AXI_WIDTH_SID-1:0]          S_AWID,
  output logic [AXI_WIDTH_AD-1:0]           S_AWADDR,
  output logic [7:0]                        S_AWLEN,
  output logic [2:0]                        S_AWSIZE,
  output logic [1:0]                        S_AWBURST,
  output logic                              S_AWVALID,
  input  logic                              S_AWREADY,
  output logic [AXI_WIDTH_DA-1:0]           S_WDATA,
  output logic [AXI_WIDTH_DS-1:0]           S_WSTRB,
  output logic                              S_WLAST,
  output logic                              S_WVALID,
  input  logic                              S_WREADY,
  input  logic [AXI_WIDTH_SID-1:0]          S_BID,
  input  logic [1:0]                        S_BRESP,
  input  logic                              S_BVALID,
  output logic                              S_BREADY,
  output logic [AXI_WIDTH_SID-1:0]          S_ARID,
  output logic [AXI_WIDTH_AD-1:0]           S_ARADDR,
  output logic [7:0]                        S_ARLEN,
  output logic [2:0]                        S_ARSIZE,
  output logic [1:0]                        S_ARBURST,
  output logic                              S_ARVALID,
  input  logic                              S_ARREADY,
  input  logic [AXI_WIDTH_SID-1:0]          S_RID,
  input  logic [AXI_WIDTH_DA-1:0]           S_RDATA,
  input  logic [1:0]                        S_RRESP,
  input  logic                              S_RLAST,
  input  logic                              S_RVALID,
  output logic                              S_RREADY
);

  localparam int N  = NUM_MST;
  localparam int CW = AXI_WIDTH_CID;
  localparam int IW = AXI_WIDTH_ID;
  localparam int AW = AXI_WIDTH_AD;
  localparam int DW = AXI_WIDTH_DA;
  localparam int SW = AXI_WIDTH_DS;
  localparam int XW = AXI_WIDTH_SID;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wr_st_t;
  typedef enum logic {R_IDLE, R_ADDR} rd_st_t;

  wr_st_t          wr_st;
  rd_st_t          rd_st;
  logic [CW-1:0]   wg, rg, w_pick, r_pick;
  logic [CW-1:0]   bk, rk;

`ifdef AXI_ARB_RR_EN
  logic [CW-1:0]   wptr, rptr;

  // Rotate so the pointer sits at bit 0, then take the lowest set bit.
  function automatic logic [CW-1:0] pick(input logic [N-1:0] req,
                                         input logic [CW-1:0] ptr);
    logic [N-1:0] rot;
    int sel;
    rot = N'({req, req} >> ptr);
    sel = 0;
    for (int i = N-1; i >= 0; i--)
      if (rot[i]) sel = i;
    return CW'((int'(ptr) + sel) % N);
  endfunction

  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] g);
    return CW'((int'(g) + 1) % N);
  endfunction

  assign w_pick = pick(M_AWVALID, wptr);
  assign r_pick = pick(M_ARVALID, rptr);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_st == W_IDLE && |M_AWVALID) wptr <= nxt(w_pick);
      if (rd_st == R_IDLE && |M_ARVALID) rptr <= nxt(r_pick);
    end
  end
`else
  function automatic logic [CW-1:0] pick(input logic [N-1:0] req);
    logic [CW-1:0] sel;
    sel = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[i]) sel = CW'(i);
    return sel;
  endfunction

  assign w_pick = pick(M_AWVALID);
  assign r_pick = pick(M_ARVALID);
`endif

  // Grant is held through ADDR even if the master drops VALID.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_st <= W_IDLE;
      wg    <= '0;
    end else begin
      unique case (wr_st)
        W_IDLE: if (|M_AWVALID) begin
          wg    <= w_pick;
          wr_st <= W_ADDR;
        end
        W_ADDR: if (S_AWVALID && S_AWREADY) wr_st <= W_DATA;
        W_DATA: if (S_WVALID && S_WREADY && S_WLAST) wr_st <= W_IDLE;
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_st <= R_IDLE;
      rg    <= '0;
    end else begin
      unique case (rd_st)
        R_IDLE: if (|M_ARVALID) begin
          rg    <= r_pick;
          rd_st <= R_ADDR;
        end
        R_ADDR: if (S_ARVALID && S_ARREADY) rd_st <= R_IDLE;
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0;
    S_AWSIZE = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
    S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0;
    M_AWREADY = '0;
    M_WREADY  = '0;
    for (int i = 0; i < N; i++) begin
      if (wg == CW'(i)) begin
        S_AWID       = {wg, M_AWID[i*IW +: IW]};
        S_AWADDR     = M_AWADDR[i*AW +: AW];
        S_AWLEN      = M_AWLEN[i*8 +: 8];
        S_AWSIZE     = M_AWSIZE[i*3 +: 3];
        S_AWBURST    = M_AWBURST[i*2 +: 2];
        S_AWVALID    = (wr_st == W_ADDR) && M_AWVALID[i];
        M_AWREADY[i] = (wr_st == W_ADDR) && S_AWREADY;
        S_WDATA      = M_WDATA[i*DW +: DW];
        S_WSTRB      = M_WSTRB[i*SW +: SW];
        S_WLAST      = M_WLAST[i];
        S_WVALID     = (wr_st == W_DATA) && M_WVALID[i];
        M_WREADY[i]  = (wr_st == W_DATA) && S_WREADY;
      end
    end
  end

  always_comb begin
    S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0;
    S_ARSIZE = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
    M_ARREADY = '0;
    for (int i = 0; i < N; i++) begin
      if (rg == CW'(i)) begin
        S_ARID       = {rg, M_ARID[i*IW +: IW]};
        S_ARADDR     = M_ARADDR[i*AW +: AW];
        S_ARLEN      = M_ARLEN[i*8 +: 8];
        S_ARSIZE     = M_ARSIZE[i*3 +: 3];
        S_ARBURST    = M_ARBURST[i*2 +: 2];
        S_ARVALID    = (rd_st == R_ADDR) && M_ARVALID[i];
        M_ARREADY[i] = (rd_st == R_ADDR) && S_ARREADY;
      end
    end
  end

  // Responses tagged with an index beyond NUM_MST are sunk here.
  assign bk = S_BID[XW-1:IW];
  assign rk = S_RID[XW-1:IW];

  always_comb begin
    M_BID    = {N{S_BID[IW-1:0]}};
    M_BRESP  = {N{S_BRESP}};
    M_BVALID = '0;
    S_BREADY = 1'b1;
    M_RID    = {N{S_RID[IW-1:0]}};
    M_RDATA  = {N{S_RDATA}};
    M_RRESP  = {N{S_RRESP}};
    M_RLAST  = {N{S_RLAST}};
    M_RVALID = '0;
    S_RREADY = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (bk == CW'(i)) begin
        M_BVALID[i] = S_BVALID;
        S_BREADY    = M_BREADY[i];
      end
      if (rk == CW'(i)) begin
        M_RVALID[i] = S_RVALID;
        S_RREADY    = M_RREADY[i];
      end
    end
  end

endmodule
